// File: rtl/cobalt_pkg.sv
// cobalt_pkg: core-wide constants and types shared by the register
// status table, tag allocator, reservation stations and CDB arbiter.
package cobalt_pkg;

  localparam int W_ADDR = 5;
  localparam int W_TAG  = 6;
  localparam int N_REG  = 1 << W_ADDR;

  typedef logic [W_ADDR-1:0] addr_t;
  typedef logic [W_TAG-1:0]  tag_t;
  typedef logic [N_REG-1:0]  onehot_t;
  typedef logic [W_ADDR:0]   cnt_t;

endpackage

// File: rtl/register_status_table_if.sv
// register_status_table_if: dispatch/CDB/flush inputs and lookup/wen outputs.
// master = dispatch side, slave = status table; rst_busy_count under RST_BUSY_COUNT_EN.
interface register_status_table_if;
  import cobalt_pkg::*;

  logic    dispatch_rd_en;
  addr_t   dispatch_rdaddr;
  tag_t    dispatch_rdtag;
  addr_t   dispatch_rsaddr;
  addr_t   dispatch_rtaddr;
  logic    cdb_valid;
  tag_t    cdb_tag;
  logic    rst_flush;
  onehot_t rst_wen_onehot;
  logic    rst_rs_pending;
  tag_t    rst_rs_tag;
  logic    rst_rs_fwd;
  logic    rst_rt_pending;
  tag_t    rst_rt_tag;
  logic    rst_rt_fwd;
`ifdef RST_BUSY_COUNT_EN
  cnt_t    rst_busy_count;
`endif

`ifdef RST_BUSY_COUNT_EN
  modport master (
    output dispatch_rd_en, dispatch_rdaddr, dispatch_rdtag,
    output dispatch_rsaddr, dispatch_rtaddr,
    output cdb_valid, cdb_tag, rst_flush,
    input  rst_wen_onehot,
    input  rst_rs_pending, rst_rs_tag, rst_rs_fwd,
    input  rst_rt_pending, rst_rt_tag, rst_rt_fwd,
    input  rst_busy_count
  );
  modport slave (
    input  dispatch_rd_en, dispatch_rdaddr, dispatch_rdtag,
    input  dispatch_rsaddr, dispatch_rtaddr,
    input  cdb_valid, cdb_tag, rst_flush,
    output rst_wen_onehot,
    output rst_rs_pending, rst_rs_tag, rst_rs_fwd,
    output rst_rt_pending, rst_rt_tag, rst_rt_fwd,
    output rst_busy_count
  );
`else
  modport master (
    output dispatch_rd_en, dispatch_rdaddr, dispatch_rdtag,
    output dispatch_rsaddr, dispatch_rtaddr,
    output cdb_valid, cdb_tag, rst_flush,
    input  rst_wen_onehot,
    input  rst_rs_pending, rst_rs_tag, rst_rs_fwd,
    input  rst_rt_pending, rst_rt_tag, rst_rt_fwd
  );
  modport slave (
    input  dispatch_rd_en, dispatch_rdaddr, dispatch_rdtag,
    input  dispatch_rsaddr, dispatch_rtaddr,
    input  cdb_valid, cdb_tag, rst_flush,
    output rst_wen_onehot,
    output rst_rs_pending, rst_rs_tag, rst_rs_fwd,
    output rst_rt_pending, rst_rt_tag, rst_rt_fwd
  );
`endif

endinterface

// File: rtl/rst_entry.sv
// rst_entry: one register's pending state (valid + producing tag).
// Ports: clk, reset, set/set_tag (rename), cdb_valid/cdb_tag, flush -> valid, tag, match.
module rst_entry
  import cobalt_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic set,
  input  tag_t set_tag,
  input  logic cdb_valid,
  input  tag_t cdb_tag,
  input  logic flush,
  output logic valid,
  output tag_t tag,
  output logic match
);

  assign match = cdb_valid & valid & (tag == cdb_tag);

  // A rename beats a same-cycle completion: the old value still gets
  // written via match, but the entry now waits on the new tag.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      tag   <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (set) begin
      valid <= 1'b1;
      tag   <= set_tag;
    end else if (match) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/register_status_table.sv
// register_status_table: per-register pending tag, CDB match -> regfile wen, rs/rt lookup.
// Ports: clk, reset (sync, active-high), bus (slave). RST_BUSY_COUNT_EN adds rst_busy_count.
module register_status_table
  import cobalt_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  register_status_table_if.slave  bus
);

  onehot_t          valid_v;
  onehot_t          match_v;
  logic [N_REG-1:1] set_v;
  tag_t             tag_v [N_REG];

  // r0 is hardwired: never pending, never written.
  assign valid_v[0] = 1'b0;
  assign match_v[0] = 1'b0;
  assign tag_v[0]   = '0;

  for (genvar i = 1; i < N_REG; i++) begin : g_ent
    assign set_v[i] = bus.dispatch_rd_en & ~bus.rst_flush
                    & (bus.dispatch_rdaddr == addr_t'(i));

    rst_entry u_ent (
      .clk       (clk),
      .reset     (reset),
      .set       (set_v[i]),
      .set_tag   (bus.dispatch_rdtag),
      .cdb_valid (bus.cdb_valid),
      .cdb_tag   (bus.cdb_tag),
      .flush     (bus.rst_flush),
      .valid     (valid_v[i]),
      .tag       (tag_v[i]),
      .match     (match_v[i])
    );
  end

  assign bus.rst_wen_onehot = reset ? '0 : match_v;

  // Lookups see pre-update state; a same-cycle rename of rs/rt is not visible.
  assign bus.rst_rs_tag     = tag_v[bus.dispatch_rsaddr];
  assign bus.rst_rs_fwd     = ~reset & match_v[bus.dispatch_rsaddr];
  assign bus.rst_rs_pending = ~reset & valid_v[bus.dispatch_rsaddr]
                            & ~match_v[bus.dispatch_rsaddr];

  assign bus.rst_rt_tag     = tag_v[bus.dispatch_rtaddr];
  assign bus.rst_rt_fwd     = ~reset & match_v[bus.dispatch_rtaddr];
  assign bus.rst_rt_pending = ~reset & valid_v[bus.dispatch_rtaddr]
                            & ~match_v[bus.dispatch_rtaddr];

`ifdef RST_BUSY_COUNT_EN
  cnt_t cnt_nxt;
  cnt_t cnt_q;

  // Count the entries' next-cycle valid so the register tracks valid_v.
  always_comb begin
    cnt_nxt = '0;
    for (int i = 1; i < N_REG; i++) begin
      if (~bus.rst_flush & (set_v[i] | (valid_v[i] & ~match_v[i])))
        cnt_nxt = cnt_nxt + cnt_t'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_nxt;
  end

  assign bus.rst_busy_count = cnt_q;
`endif

endmodule

// File: tb/tb_register_status_table.sv
// tb_register_status_table: directed vector table plus randomized run
// against a per-register valid/tag reference model.
module tb_register_status_table;
  import cobalt_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  register_status_table_if bus ();

  register_status_table dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int checks   = 0;
  int failures = 0;

  bit   mvalid [N_REG];
  tag_t mtag   [N_REG];

  typedef struct {
    bit      r;
    bit      en;
    addr_t   rd;
    tag_t    t;
    addr_t   ra;
    addr_t   rb;
    bit      cv;
    tag_t    ct;
    bit      fl;
    onehot_t oh;
    bit      rsp;
    tag_t    rst;
    bit      rsf;
    bit      rtp;
    tag_t    rtt;
    bit      rtf;
  } vec_t;

  vec_t tbl [$];

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic apply(bit r, bit en, int rd, int t, int ra, int rb,
                       bit cv, int ct, bit fl);
    reset               = r;
    bus.dispatch_rd_en  = en;
    bus.dispatch_rdaddr = addr_t'(rd);
    bus.dispatch_rdtag  = tag_t'(t);
    bus.dispatch_rsaddr = addr_t'(ra);
    bus.dispatch_rtaddr = addr_t'(rb);
    bus.cdb_valid       = cv;
    bus.cdb_tag         = tag_t'(ct);
    bus.rst_flush       = fl;
  endtask

  function automatic bit mmatch(int i);
    return (i != 0) && bus.cdb_valid && mvalid[i] && (mtag[i] == bus.cdb_tag);
  endfunction

  function automatic int mcount();
    int n = 0;
    for (int i = 0; i < N_REG; i++) n += int'(mvalid[i]);
    return n;
  endfunction

  task automatic check_model();
    onehot_t oh = '0;
    int ra = int'(bus.dispatch_rsaddr);
    int rb = int'(bus.dispatch_rtaddr);
    for (int i = 1; i < N_REG; i++) oh[i] = !reset && mmatch(i);
    chk("mdl_onehot", bus.rst_wen_onehot, oh);
    chk("mdl_rs_pend", bus.rst_rs_pending, !reset && mvalid[ra] && !mmatch(ra));
    chk("mdl_rs_fwd", bus.rst_rs_fwd, !reset && mmatch(ra));
    chk("mdl_rs_tag", bus.rst_rs_tag, mtag[ra]);
    chk("mdl_rt_pend", bus.rst_rt_pending, !reset && mvalid[rb] && !mmatch(rb));
    chk("mdl_rt_fwd", bus.rst_rt_fwd, !reset && mmatch(rb));
    chk("mdl_rt_tag", bus.rst_rt_tag, mtag[rb]);
`ifdef RST_BUSY_COUNT_EN
    chk("mdl_busy_count", bus.rst_busy_count, mcount());
`endif
  endtask

  task automatic step_model();
    bit m [N_REG];
    for (int i = 0; i < N_REG; i++) m[i] = mmatch(i);
    for (int i = 0; i < N_REG; i++) begin
      if (reset) begin
        mvalid[i] = 0;
        mtag[i]   = '0;
      end else if (bus.rst_flush) begin
        mvalid[i] = 0;
      end else if (i != 0 && bus.dispatch_rd_en
                   && int'(bus.dispatch_rdaddr) == i) begin
        mvalid[i] = 1;
        mtag[i]   = bus.dispatch_rdtag;
      end else if (m[i]) begin
        mvalid[i] = 0;
      end
    end
  endtask

  task automatic sample();
    @(negedge clk);
    check_model();
  endtask

  task automatic advance();
    @(posedge clk);
    step_model();
    #1;
  endtask

  function automatic bit tag_used(tag_t t);
    for (int i = 1; i < N_REG; i++)
      if (mvalid[i] && mtag[i] == t) return 1;
    return 0;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < N_REG; i++) begin
      mvalid[i] = 0;
      mtag[i]   = '0;
    end

    // reset two cycles, second one checked
    apply(1, 0, 0, 0, 1, 1, 0, 0, 0);
    #1;
    advance();
    sample();
    chk("reset_onehot", bus.rst_wen_onehot, 0);
    advance();

    // all registers idle after reset
    for (int i = 1; i < N_REG; i++) begin
      apply(0, 0, 0, 0, i, N_REG - i, 0, 0, 0);
      sample();
      chk("idle_rs_pend", bus.rst_rs_pending, 0);
      chk("idle_rs_fwd", bus.rst_rs_fwd, 0);
      chk("idle_rt_pend", bus.rst_rt_pending, 0);
      advance();
    end

    //            r en rd t  ra rb cv ct fl  oh     rsp rst rsf rtp rtt rtf
    tbl.push_back('{1, 1, 5, 3, 5, 31, 1, 0, 0, 32'h0,  0, 0, 0, 0, 0, 0});
    tbl.push_back('{0, 1, 5, 3, 5, 31, 0, 0, 0, 32'h0,  0, 0, 0, 0, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 5, 31, 0, 0, 0, 32'h0,  1, 3, 0, 0, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 5, 31, 1, 3, 0, 32'h20, 0, 3, 1, 0, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 5, 31, 0, 0, 0, 32'h0,  0, 3, 0, 0, 0, 0});
    tbl.push_back('{0, 1, 7, 4, 7, 31, 0, 0, 0, 32'h0,  0, 0, 0, 0, 0, 0});
    tbl.push_back('{0, 1, 7, 9, 7, 7,  1, 4, 0, 32'h80, 0, 4, 1, 0, 4, 1});
    tbl.push_back('{0, 0, 0, 0, 7, 31, 0, 0, 0, 32'h0,  1, 9, 0, 0, 0, 0});
    tbl.push_back('{0, 1, 0, 1, 0, 31, 0, 0, 0, 32'h0,  0, 0, 0, 0, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 0, 31, 1, 1, 0, 32'h0,  0, 0, 0, 0, 0, 0});
    tbl.push_back('{0, 1, 2, 1, 2, 31, 0, 0, 0, 32'h0,  0, 0, 0, 0, 0, 0});
    tbl.push_back('{0, 1, 3, 2, 2, 31, 0, 0, 0, 32'h0,  1, 1, 0, 0, 0, 0});
    tbl.push_back('{0, 1, 4, 3, 2, 3,  0, 0, 0, 32'h0,  1, 1, 0, 1, 2, 0});
    tbl.push_back('{0, 1, 6, 5, 3, 4,  1, 2, 1, 32'h8,  0, 2, 1, 1, 3, 0});
    tbl.push_back('{0, 0, 0, 0, 2, 4,  0, 0, 0, 32'h0,  0, 1, 0, 0, 3, 0});
    tbl.push_back('{0, 0, 0, 0, 2, 6,  1, 1, 0, 32'h0,  0, 1, 0, 0, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 7, 31, 0, 0, 0, 32'h0,  0, 9, 0, 0, 0, 0});

    foreach (tbl[k]) begin
      apply(tbl[k].r, tbl[k].en, int'(tbl[k].rd), int'(tbl[k].t),
            int'(tbl[k].ra), int'(tbl[k].rb), tbl[k].cv,
            int'(tbl[k].ct), tbl[k].fl);
      sample();
      chk($sformatf("v%0d_onehot", k), bus.rst_wen_onehot, tbl[k].oh);
      chk($sformatf("v%0d_rs_pend", k), bus.rst_rs_pending, tbl[k].rsp);
      chk($sformatf("v%0d_rs_tag", k), bus.rst_rs_tag, tbl[k].rst);
      chk($sformatf("v%0d_rs_fwd", k), bus.rst_rs_fwd, tbl[k].rsf);
      chk($sformatf("v%0d_rt_pend", k), bus.rst_rt_pending, tbl[k].rtp);
      chk($sformatf("v%0d_rt_tag", k), bus.rst_rt_tag, tbl[k].rtt);
      chk($sformatf("v%0d_rt_fwd", k), bus.rst_rt_fwd, tbl[k].rtf);
      advance();
    end

`ifdef RST_BUSY_COUNT_EN
    // busy counter: 3 renames, 1 completion, then reset
    apply(1, 0, 0, 0, 0, 0, 0, 0, 0);
    sample();
    advance();
    apply(0, 1, 1, 10, 0, 0, 0, 0, 0);
    sample();
    chk("cnt_after_reset", bus.rst_busy_count, 0);
    advance();
    apply(0, 1, 2, 11, 0, 0, 0, 0, 0);
    sample();
    chk("cnt_1", bus.rst_busy_count, 1);
    advance();
    apply(0, 1, 3, 12, 0, 0, 0, 0, 0);
    sample();
    chk("cnt_2", bus.rst_busy_count, 2);
    advance();
    apply(0, 0, 0, 0, 0, 0, 1, 10, 0);
    sample();
    chk("cnt_3", bus.rst_busy_count, 3);
    advance();
    apply(1, 0, 0, 0, 0, 0, 0, 0, 0);
    sample();
    chk("cnt_2b", bus.rst_busy_count, 2);
    advance();
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0);
    sample();
    chk("cnt_reset_mid", bus.rst_busy_count, 0);
    advance();
`endif

    // randomized traffic with unique tags among pending entries
    for (int n = 0; n < 1500; n++) begin
      bit   r   = ($urandom_range(0, 99) < 2);
      bit   fl  = ($urandom_range(0, 99) < 4);
      bit   en  = ($urandom_range(0, 99) < 55);
      bit   cv  = ($urandom_range(0, 99) < 60);
      int   rd  = $urandom_range(0, N_REG - 1);
      tag_t t;
      tag_t ct;
      do t = tag_t'($urandom); while (tag_used(t));
      ct = tag_t'($urandom);
      if ($urandom_range(0, 99) < 75) begin
        int p = $urandom_range(1, N_REG - 1);
        for (int j = 0; j < N_REG - 1; j++) begin
          int q = 1 + ((p - 1 + j) % (N_REG - 1));
          if (mvalid[q]) begin
            ct = mtag[q];
            break;
          end
        end
      end
      apply(r, en, rd, int'(t), $urandom_range(0, N_REG - 1),
            $urandom_range(0, N_REG - 1), cv, int'(ct), fl);
      sample();
      advance();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
